usb_fs_out_buf: RTL and testbench
=================================

USB_FS_OUT_BUF -- requirements
Module: usb_fs_out_buf

Interface
REQ-001: Parameter ENDP, default 4'd1: endpoint number this block serves.
REQ-002: Parameter DEPTH, default 64: payload FIFO depth in bytes, power of two, 8..512.
REQ-003: Parameter TIMEOUT, default 255: clk_48mhz cycles allowed between token end and data packet start.
REQ-004: clk_48mhz  in  1  48 MHz clock, sole clock.
REQ-005: reset_n  in  1  asynchronous active-low reset.
REQ-006: dev_addr  in  7  current device address.
REQ-007: rx_pkt_start, rx_pkt_end  in  1  single-cycle packet boundary pulses from the receiver.
REQ-008: rx_pid  in  4  / rx_addr  in  7 / rx_endp  in  4 : decoded packet fields, stable at rx_pkt_end.
REQ-009: rx_pkt_valid  in  1  PID/CRC check result, sampled only at rx_pkt_end.
REQ-010: rx_data_put  in  1 / rx_data  in  8 : received data byte strobe; includes the 2 trailing CRC16 bytes.
REQ-011: rd_en  in  1 / rd_data  out  8 / rd_empty  out  1 : consumer read port.
REQ-012: rd_count  out  log2(DEPTH)+1  committed bytes available.
REQ-013: hs_req  out  1  single-cycle handshake request / hs_pid  out  4  handshake PID to transmit.
REQ-014: data_toggle  out  1  expected DATA PID (0=DATA0, 1=DATA1).

Function
REQ-015: FSM states IDLE, WAIT_DATA, RX_DATA, HANDSHAKE; reset state IDLE.
REQ-016: IDLE -> WAIT_DATA at rx_pkt_end with rx_pkt_valid, rx_pid OUT(0001) or SETUP(1101), rx_addr==dev_addr, rx_endp==ENDP; all else stay IDLE.
REQ-017: SETUP token forces data_toggle to 0 at that same cycle.
REQ-018: WAIT_DATA: timeout counter reloads to TIMEOUT on entry, decrements each cycle; reaching 0 -> IDLE, no handshake.
REQ-019: WAIT_DATA -> RX_DATA on rx_pkt_start; speculative write pointer reloads to committed pointer, overflow flag clears, 2-byte delay line clears.
REQ-020: RX_DATA: each rx_data_put pushes rx_data into 2-byte delay line; byte shifted out (third and later arrivals) is written to FIFO at speculative pointer, so CRC bytes are never stored.
REQ-021: Write when speculative occupancy (spec_ptr - rd_ptr) == DEPTH sets overflow flag; byte dropped, pointer unchanged.
REQ-022: At rx_pkt_end in RX_DATA: go HANDSHAKE; outcome per REQ-023..026.
REQ-023: !rx_pkt_valid or rx_pid not DATA0(0011)/DATA1(1011): discard, no handshake, -> IDLE directly.
REQ-024: Valid, PID toggle == data_toggle, no overflow: committed pointer <= speculative pointer, data_toggle inverts, hs_pid=ACK(0010).
REQ-025: Valid, PID toggle != data_toggle: discard (duplicate), toggle unchanged, hs_pid=ACK.
REQ-026: Valid, matching toggle, overflow set: discard, toggle unchanged, hs_pid=NAK(1010).
REQ-027: HANDSHAKE: hs_req high exactly one cycle, then IDLE; hs_pid holds until next handshake.
REQ-028: Any rx_pkt_start while in RX_DATA (missed end) restarts per REQ-019 state actions, prior speculative data discarded.
REQ-029: Read: rd_en with !rd_empty advances rd_ptr; rd_data registered, valid cycle after rd_en; rd_en while empty ignored, rd_data holds.
REQ-030: rd_empty = (rd_ptr == committed pointer); rd_count = committed - rd_ptr; pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
REQ-031: Commit and read in same cycle: rd_count = old + committed bytes - 1; no byte lost or duplicated.
REQ-032: Reads during RX_DATA permitted; freed space usable by the in-flight packet.
REQ-033: Zero-length DATA packet with matching toggle: ACK, toggle inverts, rd_count unchanged.

Reset
REQ-034: reset_n low: all pointers 0, rd_data 0, rd_empty 1, rd_count 0, hs_req 0, hs_pid 0, data_toggle 0, FSM IDLE, counters 0.
REQ-035: Reset mid-packet discards all data, including committed bytes; no handshake issued.

Verification
REQ-036: OUT addr=dev_addr endp=ENDP, DATA0 of 8 bytes 01..08 + valid CRC -> hs_pid ACK, rd_count 8, reads return 01..08, data_toggle 1.
REQ-037: Repeat same DATA0 when toggle=1 -> ACK, rd_count unchanged, toggle stays 1.
REQ-038: DEPTH=8, 6 bytes unread, then DATA1 of 4 bytes -> NAK, rd_count 6, toggle unchanged.
REQ-039: DATA packet with rx_pkt_valid=0 -> hs_req never asserts, rd_count unchanged; OUT then no data for TIMEOUT cycles -> IDLE, no hs_req.
REQ-040: SETUP with toggle=1, then DATA0 of 8 bytes -> ACK, toggle 1; rd_en held across commit cycle -> count exact, all bytes read in order.
REQ-041: Token to other endp or addr -> ignored; reset_n pulsed mid-RX_DATA -> rd_empty 1, toggle 0, FSM IDLE.

Source files
------------

// File: rtl/usb_fs_out_buf_if.sv
// USB full-speed OUT endpoint buffer: receiver, read and handshake signals.
// master drives packet fields and reads; slave is the buffer.
interface usb_fs_out_buf_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [6:0]    dev_addr;
  logic          rx_pkt_start;
  logic          rx_pkt_end;
  logic [3:0]    rx_pid;
  logic [6:0]    rx_addr;
  logic [3:0]    rx_endp;
  logic          rx_pkt_valid;
  logic          rx_data_put;
  logic [7:0]    rx_data;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_empty;
  logic [CW-1:0] rd_count;
  logic          hs_req;
  logic [3:0]    hs_pid;
  logic          data_toggle;

  modport master (
    output dev_addr, rx_pkt_start, rx_pkt_end,
    output rx_pid, rx_addr, rx_endp, rx_pkt_valid,
    output rx_data_put, rx_data, rd_en,
    input  rd_data, rd_empty, rd_count,
    input  hs_req, hs_pid, data_toggle
  );

  modport slave (
    input  dev_addr, rx_pkt_start, rx_pkt_end,
    input  rx_pid, rx_addr, rx_endp, rx_pkt_valid,
    input  rx_data_put, rx_data, rd_en,
    output rd_data, rd_empty, rd_count,
    output hs_req, hs_pid, data_toggle
  );
endinterface

// File: rtl/usb_fs_out_buf.sv
// USB full-speed OUT endpoint: token match, speculative payload FIFO,
// CRC-stripping delay line, DATA toggle tracking and ACK/NAK handshake.
module usb_fs_out_buf #(
  parameter logic [3:0] ENDP    = 4'd1,
  parameter int         DEPTH   = 64,
  parameter int         TIMEOUT = 255
) (
  input logic             clk_48mhz,
  input logic             reset_n,
  usb_fs_out_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    RX_DATA,
    HANDSHAKE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] spec_q, spec_d;
  logic [PW-1:0] com_q, com_d;
  logic [PW-1:0] rd_q;
  logic          ovf_q, ovf_d;
  logic [7:0]    dly0_q, dly0_d;
  logic [7:0]    dly1_q, dly1_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic          tog_q, tog_d;
  logic [3:0]    hpid_q, hpid_d;
  logic [7:0]    rdat_q;
  logic [7:0]    mem_q [DEPTH];

  logic          wr_en;
  logic          empty;
  logic          rd_fire;
  logic          tok_hit;
  logic          tok_pid;
  logic          is_data;
  logic [PW-1:0] occ;

  assign tok_pid = (bus.rx_pid == PID_OUT) ||
                   (bus.rx_pid == PID_SETUP);
  assign tok_hit = bus.rx_pkt_end && bus.rx_pkt_valid &&
                   tok_pid &&
                   (bus.rx_addr == bus.dev_addr) &&
                   (bus.rx_endp == ENDP);
  assign is_data = (bus.rx_pid[2:0] == 3'b011);
  assign occ     = spec_q - rd_q;
  assign empty   = (rd_q == com_q);
  assign rd_fire = bus.rd_en && !empty;

  assign bus.rd_empty    = empty;
  assign bus.rd_count    = com_q - rd_q;
  assign bus.rd_data     = rdat_q;
  assign bus.hs_req      = (state_q == HANDSHAKE);
  assign bus.hs_pid      = hpid_q;
  assign bus.data_toggle = tog_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    spec_d  = spec_q;
    ovf_d   = ovf_q;
    dly0_d  = dly0_q;
    dly1_d  = dly1_q;
    dcnt_d  = dcnt_q;
    com_d   = com_q;
    tog_d   = tog_q;
    hpid_d  = hpid_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tok_hit) begin
          state_d = WAIT_DATA;
          tmo_d   = TMO;
          if (bus.rx_pid == PID_SETUP) tog_d = 1'b0;
        end
      end
      WAIT_DATA: begin
        if (bus.rx_pkt_start) begin
          state_d = RX_DATA;
          spec_d  = com_q;
          ovf_d   = 1'b0;
          dcnt_d  = 2'd0;
          dly0_d  = 8'd0;
          dly1_d  = 8'd0;
        end else if (tmo_q == '0) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      RX_DATA: begin
        if (bus.rx_pkt_start) begin
          spec_d = com_q;
          ovf_d  = 1'b0;
          dcnt_d = 2'd0;
          dly0_d = 8'd0;
          dly1_d = 8'd0;
        end else begin
          // the last two bytes stay in the delay line: they are the CRC
          if (bus.rx_data_put) begin
            if (dcnt_q == 2'd2) begin
              if (occ == FULL) begin
                ovf_d = 1'b1;
              end else begin
                wr_en  = 1'b1;
                spec_d = spec_q + PW'(1);
              end
            end else begin
              dcnt_d = dcnt_q + 2'd1;
            end
            dly1_d = dly0_q;
            dly0_d = bus.rx_data;
          end
          if (bus.rx_pkt_end) begin
            if (!bus.rx_pkt_valid || !is_data) begin
              state_d = IDLE;
            end else begin
              state_d = HANDSHAKE;
              if (bus.rx_pid[3] != tog_q) begin
                hpid_d = PID_ACK;
              end else if (ovf_d) begin
                hpid_d = PID_NAK;
              end else begin
                hpid_d = PID_ACK;
                com_d  = spec_d;
                tog_d  = ~tog_q;
              end
            end
          end
        end
      end
      HANDSHAKE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      spec_q  <= '0;
      com_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      dly0_q  <= 8'd0;
      dly1_q  <= 8'd0;
      dcnt_q  <= 2'd0;
      tog_q   <= 1'b0;
      hpid_q  <= 4'd0;
      rdat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      spec_q  <= spec_d;
      com_q   <= com_d;
      ovf_q   <= ovf_d;
      dly0_q  <= dly0_d;
      dly1_q  <= dly1_d;
      dcnt_q  <= dcnt_d;
      tog_q   <= tog_d;
      hpid_q  <= hpid_d;
      if (rd_fire) begin
        rd_q   <= rd_q + PW'(1);
        rdat_q <= mem_q[rd_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (wr_en) mem_q[spec_q[AW-1:0]] <= dly1_q;
  end

endmodule

// File: tb/tb_usb_fs_out_buf.sv
// Bench for usb_fs_out_buf: vector table, corner sequences
// and randomized packets against a queue-based endpoint model.
module tb_usb_fs_out_buf;
  localparam int         DEPTH   = 8;
  localparam int         TIMEOUT = 20;
  localparam logic [3:0] ENDP    = 4'd3;
  localparam logic [6:0] ADDR    = 7'h2A;

  localparam logic [3:0] P_OUT = 4'b0001;
  localparam logic [3:0] P_SET = 4'b1101;
  localparam logic [3:0] P_IN  = 4'b1001;
  localparam logic [3:0] P_D0  = 4'b0011;
  localparam logic [3:0] P_D1  = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010;
  localparam logic [3:0] P_NAK = 4'b1010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_fs_out_buf_if #(.DEPTH(DEPTH)) bus ();

  usb_fs_out_buf #(
    .ENDP(ENDP),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_48mhz(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  // endpoint model: unread committed bytes plus expected toggle
  logic [7:0] expq[$];
  logic       mtog = 1'b0;
  logic [7:0] last_b = 8'd0;

  int         hs_cnt = 0;
  logic [3:0] hs_seen = 4'd0;
  always @(negedge clk) begin
    if (bus.hs_req === 1'b1) begin
      hs_cnt++;
      hs_seen = bus.hs_pid;
    end
  end

  logic rd_f;
  always @(posedge clk) begin
    rd_f = bus.rd_en && !bus.rd_empty;
    #1;
    if (rd_f) begin
      if (expq.size() == 0) begin
        chk("rd_underflow", 1, 0);
      end else begin
        last_b = expq.pop_front();
        chk("rd_data", bus.rd_data, last_b);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic token(logic [3:0] pid, logic aok,
                       logic eok, logic v);
    bus.rx_pkt_start = 1'b1;
    @(negedge clk);
    bus.rx_pkt_start = 1'b0;
    @(negedge clk);
    bus.rx_pkt_end   = 1'b1;
    bus.rx_pid       = pid;
    bus.rx_addr      = aok ? ADDR : (ADDR ^ 7'h01);
    bus.rx_endp      = eok ? ENDP : (ENDP ^ 4'h4);
    bus.rx_pkt_valid = v;
    @(negedge clk);
    bus.rx_pkt_end   = 1'b0;
    bus.rx_pkt_valid = 1'b0;
  endtask

  task automatic put(logic [7:0] b);
    bus.rx_data_put = 1'b1;
    bus.rx_data     = b;
    @(negedge clk);
    bus.rx_data_put = 1'b0;
    @(negedge clk);
  endtask

  task automatic pstart();
    bus.rx_pkt_start = 1'b1;
    @(negedge clk);
    bus.rx_pkt_start = 1'b0;
  endtask

  task automatic pend(logic [3:0] pid, logic v);
    bus.rx_pkt_end   = 1'b1;
    bus.rx_pid       = pid;
    bus.rx_pkt_valid = v;
    @(negedge clk);
    bus.rx_pkt_end   = 1'b0;
    bus.rx_pkt_valid = 1'b0;
  endtask

  task automatic send_data(logic [3:0] pid, logic v,
                           int n, logic [7:0] base);
    pstart();
    for (int i = 0; i < n; i++) put(base + 8'(i));
    put(8'($urandom));
    put(8'($urandom));
    pend(pid, v);
  endtask

  task automatic run_pkt(logic [3:0] tp, logic aok,
                         logic eok, logic tv,
                         logic [3:0] dp, logic dv, int n,
                         logic [7:0] base, output int hs,
                         output logic [3:0] pid);
    hs_cnt = 0;
    token(tp, aok, eok, tv);
    idle(2);
    send_data(dp, dv, n, base);
    idle(3);
    hs  = hs_cnt;
    pid = hs_seen;
  endtask

  task automatic read_n(int k);
    repeat (k) begin
      bus.rd_en = 1'b1;
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_bytes(int n, logic [7:0] base);
    for (int i = 0; i < n; i++) expq.push_back(base + 8'(i));
  endtask

  task automatic chk_state(string nm);
    chk({nm, "_toggle"}, bus.data_toggle, mtog);
    chk({nm, "_count"}, bus.rd_count, expq.size());
    chk({nm, "_empty"}, bus.rd_empty, expq.size() == 0);
  endtask

  // model-checked packet: outcome derived from endpoint rules
  task automatic do_pkt(string nm, logic [3:0] tp,
                        logic aok, logic eok, logic tv,
                        logic [3:0] dp, logic dv, int n,
                        logic [7:0] base);
    logic       acc;
    int         ehs;
    logic [3:0] epid;
    logic       cm;
    int         hs;
    logic [3:0] pid;
    acc = tv && aok && eok && (tp == P_OUT || tp == P_SET);
    if (acc && tp == P_SET) mtog = 1'b0;
    ehs = 0;
    epid = 4'd0;
    cm = 1'b0;
    if (acc && dv && (dp == P_D0 || dp == P_D1)) begin
      ehs = 1;
      if (dp[3] != mtog) epid = P_ACK;
      else if (expq.size() + n > DEPTH) epid = P_NAK;
      else begin
        epid = P_ACK;
        cm = 1'b1;
      end
    end
    run_pkt(tp, aok, eok, tv, dp, dv, n, base, hs, pid);
    if (cm) begin
      push_bytes(n, base);
      mtog = ~mtog;
    end
    chk({nm, "_hs_cycles"}, hs, ehs);
    if (ehs == 1) chk({nm, "_hs_pid"}, pid, epid);
    chk_state(nm);
  endtask

  typedef struct {
    logic [3:0] tp;
    logic       aok;
    logic       eok;
    logic       tv;
    logic [3:0] dp;
    logic       dv;
    int         n;
    int         hs;
    logic [3:0] hpid;
    logic       tog;
    int         cnt;
    logic       cm;
  } vec_t;

  vec_t vt[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         hs;
    logic [3:0] pid;
    logic [3:0] rdp;
    logic [7:0] keep;

    bus.dev_addr     = ADDR;
    bus.rx_pkt_start = 1'b0;
    bus.rx_pkt_end   = 1'b0;
    bus.rx_pid       = 4'd0;
    bus.rx_addr      = 7'd0;
    bus.rx_endp      = 4'd0;
    bus.rx_pkt_valid = 1'b0;
    bus.rx_data_put  = 1'b0;
    bus.rx_data      = 8'd0;
    bus.rd_en        = 1'b0;

    // start: toggle 1, empty FIFO
    vt[0]  = '{P_OUT,1,1,1,P_D1,1,6,1,P_ACK,0,6,1};
    vt[1]  = '{P_OUT,1,1,1,P_D0,1,4,1,P_NAK,0,6,0};
    vt[2]  = '{P_OUT,0,1,1,P_D0,1,1,0,4'd0,0,6,0};
    vt[3]  = '{P_OUT,1,0,1,P_D0,1,1,0,4'd0,0,6,0};
    vt[4]  = '{P_OUT,1,1,0,P_D0,1,1,0,4'd0,0,6,0};
    vt[5]  = '{P_OUT,1,1,1,P_D0,0,2,0,4'd0,0,6,0};
    vt[6]  = '{P_OUT,1,1,1,P_ACK,1,0,0,4'd0,0,6,0};
    vt[7]  = '{P_OUT,1,1,1,P_D0,1,0,1,P_ACK,1,6,1};
    vt[8]  = '{P_OUT,1,1,1,P_D1,1,2,1,P_ACK,0,8,1};
    vt[9]  = '{P_OUT,1,1,1,P_D1,1,1,1,P_ACK,0,8,0};
    vt[10] = '{P_OUT,1,1,1,P_D0,1,1,1,P_NAK,0,8,0};
    vt[11] = '{P_IN,1,1,1,P_D0,1,1,0,4'd0,0,8,0};

    idle(3);
    chk("rst_empty", bus.rd_empty, 1);
    chk("rst_count", bus.rd_count, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_hs_req", bus.hs_req, 0);
    chk("rst_hs_pid", bus.hs_pid, 0);
    chk("rst_toggle", bus.data_toggle, 0);
    rst_n = 1'b1;
    idle(2);

    do_pkt("d0_8", P_OUT, 1, 1, 1, P_D0, 1, 8, 8'h01);
    do_pkt("d0_dup", P_OUT, 1, 1, 1, P_D0, 1, 8, 8'h01);
    read_n(8);
    chk_state("drain1");

    for (int r = 0; r < 12; r++) begin
      run_pkt(vt[r].tp, vt[r].aok, vt[r].eok, vt[r].tv,
              vt[r].dp, vt[r].dv, vt[r].n,
              8'(16 * (r + 1)), hs, pid);
      if (vt[r].cm) push_bytes(vt[r].n, 8'(16 * (r + 1)));
      mtog = vt[r].tog;
      chk($sformatf("vec%0d_hs", r), hs, vt[r].hs);
      if (vt[r].hs == 1)
        chk($sformatf("vec%0d_pid", r), pid, vt[r].hpid);
      chk($sformatf("vec%0d_tog", r), bus.data_toggle,
          vt[r].tog);
      chk($sformatf("vec%0d_cnt", r), bus.rd_count,
          vt[r].cnt);
    end
    read_n(8);
    chk_state("drain2");

    keep = last_b;
    read_n(2);
    chk("empty_rd_hold", bus.rd_data, keep);
    chk("empty_rd_count", bus.rd_count, 0);

    // token answered too late: data must be ignored
    hs_cnt = 0;
    token(P_OUT, 1, 1, 1);
    idle(TIMEOUT + 5);
    send_data(P_D0, 1, 3, 8'hC0);
    idle(3);
    chk("tmo_hs", hs_cnt, 0);
    chk_state("tmo");

    hs_cnt = 0;
    token(P_OUT, 1, 1, 1);
    idle(TIMEOUT - 5);
    send_data(P_D0, 1, 3, 8'hC0);
    idle(3);
    push_bytes(3, 8'hC0);
    mtog = 1'b1;
    chk("intime_hs", hs_cnt, 1);
    chk("intime_pid", hs_seen, P_ACK);
    chk_state("intime");
    read_n(3);

    // commit and read in the same cycle
    do_pkt("old4", P_OUT, 1, 1, 1, P_D1, 1, 4, 8'hD0);
    hs_cnt = 0;
    token(P_OUT, 1, 1, 1);
    idle(2);
    pstart();
    for (int i = 0; i < 6; i++) put(8'hE0 + 8'(i));
    push_bytes(4, 8'hE0);
    mtog = 1'b1;
    bus.rd_en = 1'b1;
    pend(P_D0, 1);
    chk("same_cyc_count", bus.rd_count, 7);
    idle(9);
    bus.rd_en = 1'b0;
    idle(2);
    chk("same_cyc_hs", hs_seen, P_ACK);
    chk_state("same_cyc");

    // SETUP, then full packet made to fit by reads in flight
    do_pkt("old4b", P_OUT, 1, 1, 1, P_D1, 1, 4, 8'hA0);
    do_pkt("zlp", P_OUT, 1, 1, 1, P_D0, 1, 0, 8'h00);
    hs_cnt = 0;
    token(P_SET, 1, 1, 1);
    mtog = 1'b0;
    chk("setup_tog", bus.data_toggle, 0);
    idle(1);
    bus.rd_en = 1'b1;
    send_data(P_D0, 1, 8, 8'h50);
    push_bytes(8, 8'h50);
    mtog = 1'b1;
    chk("setup_cnt8", bus.rd_count, 8);
    @(negedge clk);
    chk("setup_cnt7", bus.rd_count, 7);
    idle(10);
    bus.rd_en = 1'b0;
    idle(2);
    chk("setup_hs", hs_cnt, 1);
    chk("setup_pid", hs_seen, P_ACK);
    chk_state("setup");

    // a second start mid-packet discards the first attempt
    hs_cnt = 0;
    token(P_OUT, 1, 1, 1);
    idle(2);
    pstart();
    for (int i = 0; i < 5; i++) put(8'h70 + 8'(i));
    pstart();
    for (int i = 0; i < 5; i++) put(8'h80 + 8'(i));
    pend(P_D1, 1);
    idle(3);
    push_bytes(3, 8'h80);
    mtog = 1'b0;
    chk("restart_pid", hs_seen, P_ACK);
    chk_state("restart");

    // reset in the middle of a packet
    do_pkt("pre_rst", P_OUT, 1, 1, 1, P_D0, 1, 2, 8'h90);
    hs_cnt = 0;
    token(P_OUT, 1, 1, 1);
    idle(2);
    pstart();
    for (int i = 0; i < 3; i++) put(8'hB0 + 8'(i));
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    expq.delete();
    mtog = 1'b0;
    for (int i = 0; i < 4; i++) put(8'hB3 + 8'(i));
    pend(P_D0, 1);
    idle(3);
    chk("rst_mid_hs", hs_cnt, 0);
    chk("rst_mid_rd_data", bus.rd_data, 0);
    chk_state("rst_mid");

    for (int k = 0; k < 40; k++) begin
      logic [3:0] tp;
      logic [3:0] dp;
      int         sel;
      sel = $urandom_range(0, 5);
      tp = (sel < 4) ? P_OUT : ((sel == 4) ? P_SET : P_IN);
      sel = $urandom_range(0, 4);
      dp = (sel < 2) ? P_D0 : ((sel < 4) ? P_D1 : P_ACK);
      do_pkt($sformatf("rnd%0d", k), tp,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 9) != 0,
             $urandom_range(0, 9) != 0, dp,
             $urandom_range(0, 7) != 0,
             $urandom_range(0, 8), 8'($urandom));
      rdp = 4'($urandom_range(0, expq.size()));
      read_n(int'(rdp));
      chk($sformatf("rnd%0d_rd_cnt", k), bus.rd_count,
          expq.size());
    end
    read_n(expq.size());
    chk_state("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
